// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter with TX FIFO; optional parity bit via UART_TX_PARITY_EN
module uart_tx #(
  parameter int DataWidth = 8,
  parameter int FifoDepth = 4,
  parameter int ParityOdd = 0
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 baud_clk_i,
  input  logic [DataWidth-1:0] data_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  output logic                 txd_o,
  output logic                 busy_o,
  output logic                 done_o
);

  localparam int PtrW = $clog2(FifoDepth);
  localparam int CntW = PtrW + 1;
  localparam int BitW = (DataWidth > 1) ? $clog2(DataWidth) : 1;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_STOP   = 3'd4;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] ST_PARITY = 3'd3;
`endif

  logic [DataWidth-1:0] r_mem [FifoDepth];
  logic [PtrW-1:0]      r_wptr;
  logic [PtrW-1:0]      r_rptr;
  logic [CntW-1:0]      r_count;
  logic [2:0]           r_state;
  logic [DataWidth-1:0] r_sreg;
  logic [BitW-1:0]      r_bitcnt;
  logic                 r_txd;

  logic                 w_push;
  logic                 w_pop;
  logic                 w_nempty;
  logic                 w_load_slot;
  logic [DataWidth-1:0] w_head;

  assign w_nempty    = (r_count != '0);
  assign ready_o     = (r_count != CntW'(FifoDepth));
  assign w_push      = valid_i && ready_o;
  // A byte leaves the FIFO only when the line is free for a new start bit.
  assign w_load_slot = (r_state == ST_IDLE) || (r_state == ST_STOP);
  assign w_pop       = baud_clk_i && w_load_slot && w_nempty;
  assign w_head      = r_mem[r_rptr];

  assign txd_o  = r_txd;
  assign busy_o = (r_state != ST_IDLE) || w_nempty;
  assign done_o = baud_clk_i && (r_state == ST_STOP);

  // FIFO storage; contents need no reset since the count gates every read.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wptr] <= data_i;
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop leave the count unchanged.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PtrW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PtrW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CntW'(1);
        2'b01:   r_count <= r_count - CntW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef UART_TX_PARITY_EN
  logic r_parity;

  // Capture the frame's parity when its byte is loaded.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_parity <= 1'b0;
    end else if (w_pop) begin
      r_parity <= (^w_head) ^ (ParityOdd != 0);
    end
  end
`else
  logic w_unused_parity_odd;
  assign w_unused_parity_odd = (ParityOdd != 0);
`endif

  // Frame sequencer: every line bit advances on one baud tick; the line is registered.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= ST_IDLE;
      r_sreg   <= '0;
      r_bitcnt <= '0;
      r_txd    <= 1'b1;
    end else if (baud_clk_i) begin
      case (r_state)
        ST_IDLE: begin
          r_txd <= 1'b1;
          if (w_nempty) begin
            r_sreg  <= w_head;
            r_txd   <= 1'b0;
            r_state <= ST_START;
          end
        end
        ST_START: begin
          r_txd    <= r_sreg[0];
          r_sreg   <= r_sreg >> 1;
          r_bitcnt <= '0;
          r_state  <= ST_DATA;
        end
        ST_DATA: begin
          if (r_bitcnt == BitW'(DataWidth - 1)) begin
`ifdef UART_TX_PARITY_EN
            r_txd   <= r_parity;
            r_state <= ST_PARITY;
`else
            r_txd   <= 1'b1;
            r_state <= ST_STOP;
`endif
          end else begin
            r_txd    <= r_sreg[0];
            r_sreg   <= r_sreg >> 1;
            r_bitcnt <= r_bitcnt + BitW'(1);
          end
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          r_txd   <= 1'b1;
          r_state <= ST_STOP;
        end
`endif
        ST_STOP: begin
          // Chain straight into the next start bit when more data is queued.
          if (w_nempty) begin
            r_sreg  <= w_head;
            r_txd   <= 1'b0;
            r_state <= ST_START;
          end else begin
            r_txd   <= 1'b1;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_txd   <= 1'b1;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - scoreboard bench for uart_tx: serial line decoded per baud tick and matched to pushed bytes
`timescale 1ns/1ps
module tb_uart_tx;

  localparam int DW      = 8;
  localparam int PAR_ODD = 0;
`ifdef UART_TX_PARITY_EN
  localparam int PRE_STOP_TICKS = DW + 3;
`else
  localparam int PRE_STOP_TICKS = DW + 2;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       auto_tick = 1'b0;
  logic       man_tick = 1'b0;
  logic       baud;
  logic [7:0] data = 8'h00;
  logic       valid = 1'b0;
  wire        ready;
  wire        txd;
  wire        busy;
  wire        done;

  assign baud = auto_tick | man_tick;

  int div  = 0;
  int bcnt = 0;
  int vectors = 0;
  int miscompares = 0;

  logic [7:0] exp_q[$];
  int         rx_active = 0;
  int         rx_pos = 0;
  int         idle_run = 1;
  int         frames = 0;
  int         b2b = 0;
  int         done_cnt = 0;
  int         ready_drops = 0;
  bit         watch_ready = 1'b0;
  logic [7:0] rx_byte = 8'h00;

  logic [7:0] t3v [6] = '{8'h00, 8'hFF, 8'h55, 8'hAA, 8'h01, 8'h80};

  uart_tx #(.DataWidth(DW), .FifoDepth(4), .ParityOdd(PAR_ODD)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .baud_clk_i (baud),
    .data_i     (data),
    .valid_i    (valid),
    .ready_o    (ready),
    .txd_o      (txd),
    .busy_o     (busy),
    .done_o     (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (div <= 0) begin
      auto_tick = 1'b0;
      bcnt = 0;
    end else if (div == 1) begin
      auto_tick = 1'b1;
      bcnt = 0;
    end else begin
      bcnt = bcnt + 1;
      if (bcnt >= div) bcnt = 0;
      auto_tick = (bcnt == 0);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Line receiver: one sample per baud tick is the bit held during the period just ended.
  always @(negedge clk) begin
    if (!rst_n) begin
      rx_active = 0;
      rx_pos = 0;
      idle_run = 1;
    end else begin
      if (done) done_cnt++;
      if (watch_ready && !ready) ready_drops++;
      if (baud) begin
        if (rx_active != 0) begin
          rx_pos++;
          if (rx_pos <= DW) begin
            rx_byte[rx_pos-1] = txd;
            chk("done_in_data", done, 0);
          end
`ifdef UART_TX_PARITY_EN
          else if (rx_pos == DW + 1) begin
            chk("parity_bit", txd, (^rx_byte) ^ PAR_ODD);
            chk("done_in_parity", done, 0);
          end
`endif
          else begin
            chk("stop_bit", txd, 1);
            chk("done_on_stop", done, 1);
            if (exp_q.size() == 0) begin
              vectors++;
              miscompares++;
              $display("FAIL rx_unexpected: got frame %02h, expected no frame", rx_byte);
            end else begin
              chk("rx_byte", rx_byte, exp_q.pop_front());
            end
            frames++;
            rx_active = 0;
            idle_run = 0;
          end
        end else begin
          chk("done_in_idle", done, 0);
          if (txd == 1'b0) begin
            rx_active = 1;
            rx_pos = 0;
            if (idle_run == 0) b2b++;
          end else begin
            idle_run++;
          end
        end
      end else begin
        chk("done_without_tick", done, 0);
      end
    end
  end

  task automatic push(input logic [7:0] b);
    int n;
    n = 0;
    data = b;
    valid = 1'b1;
    forever begin
      @(negedge clk);
      if (ready) break;
      n++;
      if (n > 5000) begin
        vectors++;
        miscompares++;
        $display("FAIL push_timeout: got ready=0 for 5000 cycles, expected ready=1");
        valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    #1;
    valid = 1'b0;
    exp_q.push_back(b);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while ((busy || exp_q.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_timeout: got busy=%0d pending=%0d, expected idle", name, busy, exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    man_tick = 1'b1;
    @(posedge clk);
    #1;
    man_tick = 1'b0;
  endtask

  initial begin
    int f0;
    int d0;
    int b0;
    int k;
    logic [7:0] vd;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_txd", txd, 1);
    chk("reset_ready", ready, 1);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single byte 0xA5 at 16 clocks per tick.
    div = 16;
    f0 = frames; d0 = done_cnt; b0 = b2b;
    ready_drops = 0;
    watch_ready = 1'b1;
    push(8'hA5);
    wait_idle("t1", 3000);
    watch_ready = 1'b0;
    chk("t1_frames", frames - f0, 1);
    chk("t1_done_pulses", done_cnt - d0, 1);
    chk("t1_busy", busy, 0);
    chk("t1_ready_drops", ready_drops, 0);
    chk("t1_b2b", b2b - b0, 0);

    // FIFO fill with ticks stopped, then back-to-back drain.
    div = 0;
    repeat (3) @(posedge clk);
    #1;
    f0 = frames; b0 = b2b;
    for (int i = 0; i < 4; i++) push(8'($urandom_range(0, 255)));
    chk("t2_full_ready", ready, 0);
    fork
      push(8'($urandom_range(0, 255)));
      begin
        repeat (20) @(negedge clk);
        chk("t2_stall_ready", ready, 0);
        chk("t2_stall_pending", exp_q.size(), 4);
        div = 16;
      end
    join
    wait_idle("t2", 4000);
    chk("t2_frames", frames - f0, 5);
    chk("t2_b2b", b2b - b0, 4);

    // Pointer wrap-around.
    div = 4;
    f0 = frames;
    for (int i = 0; i < 3; i++) push(8'($urandom_range(0, 255)));
    wait_idle("t3a", 2000);
    for (int i = 0; i < 6; i++) push(t3v[i]);
    wait_idle("t3b", 2000);
    chk("t3_frames", frames - f0, 9);

    // Push coinciding with the StopBit pop at count 2.
    div = 0;
    repeat (3) @(posedge clk);
    #1;
    f0 = frames;
    for (int i = 0; i < 3; i++) push(8'($urandom_range(0, 255)));
    for (int i = 0; i < PRE_STOP_TICKS; i++) tick();
    vd = 8'($urandom_range(0, 255));
    data = vd;
    valid = 1'b1;
    man_tick = 1'b1;
    @(negedge clk);
    chk("t4_ready_at_stop", ready, 1);
    chk("t4_done_at_stop", done, 1);
    @(posedge clk);
    #1;
    valid = 1'b0;
    man_tick = 1'b0;
    exp_q.push_back(vd);
    push(8'($urandom_range(0, 255)));
    chk("t4_ready_count3", ready, 1);
    push(8'($urandom_range(0, 255)));
    chk("t4_ready_count4", ready, 0);
    div = 16;
    wait_idle("t4", 4000);
    chk("t4_frames", frames - f0, 6);

    // Reset during data bit 3 of 0x3C.
    div = 4;
    push(8'h3C);
    k = 0;
    while (txd !== 1'b0 && k < 500) begin
      @(negedge clk);
      k++;
    end
    chk("t5_start_seen", (txd === 1'b0) ? 1 : 0, 1);
    k = 0;
    for (int n = 0; n < 500 && k < 4; n++) begin
      @(negedge clk);
      if (baud) k++;
    end
    @(negedge clk);
    chk("t5_busy_midframe", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_txd_in_reset", txd, 1);
    chk("t5_busy_in_reset", busy, 0);
    chk("t5_ready_in_reset", ready, 1);
    chk("t5_done_in_reset", done, 0);
    exp_q.delete();
    f0 = frames;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b1;
    repeat (200) @(negedge clk);
    chk("t5_no_residual_frame", frames - f0, 0);
    chk("t5_busy_after", busy, 0);
    chk("t5_txd_after", txd, 1);
    chk("t5_rx_idle", rx_active, 0);
    @(posedge clk);
    #1;

    // Randomised traffic across baud rates, including continuous ticks.
    f0 = frames;
    for (int c = 0; c < 4; c++) begin
      case ($urandom_range(0, 3))
        0: div = 1;
        1: div = 2;
        2: div = 5;
        default: div = 16;
      endcase
      for (int i = 0; i < 6; i++) begin
        push(8'($urandom_range(0, 255)));
        repeat ($urandom_range(0, 20)) @(posedge clk);
        #1;
      end
      wait_idle("t6", 20000);
    end
    chk("t6_frames", frames - f0, 24);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
